// File: rtl/glb_ld_addr_gen.sv
// Load-DMA bank address generator: walks a nested loop of up to LOOP_LEVEL dimensions,
// emitting one byte address per valid/ready handshake, using incremental per-level bases.
module glb_ld_addr_gen #(
  parameter int unsigned LOOP_LEVEL     = 8,
  parameter int unsigned GLB_ADDR_WIDTH = 18,
  parameter int unsigned RANGE_WIDTH    = 17,
  parameter int unsigned DIM_WIDTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DIM_WIDTH-1:0]                 cfg_dim,
  input  logic [GLB_ADDR_WIDTH-1:0]            cfg_start_addr,
  input  logic [LOOP_LEVEL*RANGE_WIDTH-1:0]    cfg_range,
  input  logic [LOOP_LEVEL*GLB_ADDR_WIDTH-1:0] cfg_stride,
  input  logic                                 start,
  output logic                                 addr_valid,
  input  logic                                 addr_ready,
  output logic [GLB_ADDR_WIDTH-1:0]            addr,
  output logic                                 addr_last,
  output logic                                 busy,
  output logic                                 done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [RANGE_WIDTH-1:0] RANGE_ONE = RANGE_WIDTH'(1);

  state_t r_state, w_state_nxt;

  logic [LOOP_LEVEL-1:0]     r_act, w_act_cfg;
  logic [RANGE_WIDTH-1:0]    r_rm1 [LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0]    w_rm1_cfg [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0] r_stride [LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0]    r_i [LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0]    w_i_nxt [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0] r_base [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0] w_base_nxt [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0] w_new_base;
  logic [LOOP_LEVEL-1:0]     w_touched;
  logic                      r_valid, r_last, r_done;
  logic                      w_last_nxt, w_start_last;
  logic                      w_launch, w_fire;
  int unsigned               w_dim_eff;

  assign w_launch = (r_state == ST_IDLE) && start;
  assign w_fire   = r_valid && addr_ready;

  // Configuration decode: clamp dimension count, normalise range 0 to 1 (stored as range-1)
  always_comb begin
    w_dim_eff = 32'(cfg_dim);
    if (w_dim_eff == 0)
      w_dim_eff = 1;
    else if (w_dim_eff > LOOP_LEVEL)
      w_dim_eff = LOOP_LEVEL;
    w_start_last = 1'b1;
    for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
      w_act_cfg[k] = (k < w_dim_eff);
      if (cfg_range[k*RANGE_WIDTH +: RANGE_WIDTH] == '0)
        w_rm1_cfg[k] = '0;
      else
        w_rm1_cfg[k] = cfg_range[k*RANGE_WIDTH +: RANGE_WIDTH] - RANGE_ONE;
      if (w_act_cfg[k] && (w_rm1_cfg[k] != '0))
        w_start_last = 1'b0;
    end
  end

  // r_base[k] = start + sum_{j>=k} i[j]*stride[j]; the level that absorbs the carry
  // advances its base, and every level below it restarts from that new base.
  always_comb begin
    logic carry;
    carry      = 1'b1;
    w_new_base = r_base[0];
    for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
      w_i_nxt[k]   = r_i[k];
      w_touched[k] = r_act[k] && carry;
      if (r_act[k] && carry) begin
        if (r_i[k] == r_rm1[k]) begin
          w_i_nxt[k] = '0;
        end else begin
          w_i_nxt[k] = r_i[k] + RANGE_ONE;
          w_new_base = r_base[k] + r_stride[k];
          carry      = 1'b0;
        end
      end
    end
    w_last_nxt = 1'b1;
    for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
      w_base_nxt[k] = w_touched[k] ? w_new_base : r_base[k];
      if (r_act[k] && (w_i_nxt[k] != r_rm1[k]))
        w_last_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fire && r_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_act   <= '0;
      for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
        r_rm1[k]    <= '0;
        r_stride[k] <= '0;
        r_i[k]      <= '0;
        r_base[k]   <= '0;
      end
    end else if (w_launch) begin
      r_valid <= 1'b1;
      r_last  <= w_start_last;
      r_done  <= 1'b0;
      r_act   <= w_act_cfg;
      for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
        r_rm1[k]    <= w_rm1_cfg[k];
        r_stride[k] <= cfg_stride[k*GLB_ADDR_WIDTH +: GLB_ADDR_WIDTH];
        r_i[k]      <= '0;
        r_base[k]   <= cfg_start_addr;
      end
    end else if (w_fire) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_last <= w_last_nxt;
        r_done <= 1'b0;
        for (int unsigned k = 0; k < LOOP_LEVEL; k++) begin
          r_i[k]    <= w_i_nxt[k];
          r_base[k] <= w_base_nxt[k];
        end
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign addr_valid = r_valid;
  assign addr       = r_base[0];
  assign addr_last  = r_last;
  assign busy       = (r_state == ST_RUN);
  assign done       = r_done;

endmodule

// File: tb/tb_glb_ld_addr_gen.sv
// Directed self-checking bench for glb_ld_addr_gen; outputs sampled on the falling edge.
module tb_glb_ld_addr_gen;

  localparam int LL = 8;
  localparam int AW = 18;
  localparam int RW = 17;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     cfg_dim;
  logic [AW-1:0]     cfg_start_addr;
  logic [LL*RW-1:0]  cfg_range;
  logic [LL*AW-1:0]  cfg_stride;
  logic              start;
  logic              addr_valid;
  logic              addr_ready;
  logic [AW-1:0]     addr;
  logic              addr_last;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  glb_ld_addr_gen #(
    .LOOP_LEVEL(LL),
    .GLB_ADDR_WIDTH(AW),
    .RANGE_WIDTH(RW),
    .DIM_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_dim(cfg_dim),
    .cfg_start_addr(cfg_start_addr),
    .cfg_range(cfg_range),
    .cfg_stride(cfg_stride),
    .start(start),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr(addr),
    .addr_last(addr_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Unused levels get non-trivial values so ignoring them is actually exercised.
  task automatic set_cfg(input logic [DW-1:0] dim, input logic [AW-1:0] sa,
                         input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                         input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    cfg_dim        = dim;
    cfg_start_addr = sa;
    for (int k = 0; k < LL; k++) begin
      cfg_range[k*RW +: RW]  = 17'd5;
      cfg_stride[k*AW +: AW] = 18'h01000;
    end
    cfg_range[0 +: RW]   = r0;
    cfg_range[RW +: RW]  = r1;
    cfg_stride[0 +: AW]  = s0;
    cfg_stride[AW +: AW] = s1;
  endtask

  task automatic launch(input logic [DW-1:0] dim, input logic [AW-1:0] sa,
                        input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                        input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    @(negedge clk);
    set_cfg(dim, sa, r0, r1, s0, s1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    set_cfg(4'd1, 18'h00100, 17'd4, 17'd1, 18'd8, 18'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({addr_valid, addr, addr_last, busy, done} !== {1'b0, 18'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: valid=%b addr=%h last=%b busy=%b done=%b, want all 0",
               addr_valid, addr, addr_last, busy, done);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({addr_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_beats_start: valid=%b busy=%b, want 0 0", addr_valid, busy);
    end
  endtask

  task automatic test_1d();
    logic [AW-1:0] exp_a [4] = '{18'h00100, 18'h00108, 18'h00110, 18'h00118};
    addr_ready = 1'b1;
    launch(4'd1, 18'h00100, 17'd4, 17'd7, 18'd8, 18'h00400);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if ({addr_valid, busy, addr_last, addr} !== {1'b1, 1'b1, (n == 3), exp_a[n]}) begin
        n_errors++;
        $display("FAIL 1d_addr[%0d]: valid=%b busy=%b last=%b addr=%h, want 1 1 %b %h",
                 n, addr_valid, busy, addr_last, addr, (n == 3), exp_a[n]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, busy, addr_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL 1d_done: done=%b busy=%b valid=%b, want 1 0 0", done, busy, addr_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL 1d_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_2d_carry();
    logic [AW-1:0] exp_a [6] = '{18'h0, 18'h2, 18'h4, 18'h40, 18'h42, 18'h44};
    addr_ready = 1'b1;
    launch(4'd2, 18'h0, 17'd3, 17'd2, 18'd2, 18'h40);
    for (int n = 0; n < 6; n++) begin
      n_checks++;
      if ({addr_valid, addr_last, addr} !== {1'b1, (n == 5), exp_a[n]}) begin
        n_errors++;
        $display("FAIL 2d_addr[%0d]: valid=%b last=%b addr=%h, want 1 %b %h",
                 n, addr_valid, addr_last, addr, (n == 5), exp_a[n]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL 2d_done: done=%b busy=%b, want 1 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    addr_ready = 1'b1;
    launch(4'd1, 18'h00100, 17'd4, 17'd1, 18'd8, 18'd0);
    n_checks++;
    if (addr !== 18'h00100) begin
      n_errors++;
      $display("FAIL bp_first: addr=%h, want 00100", addr);
    end
    @(negedge clk);
    addr_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({addr_valid, addr_last, addr} !== {1'b1, 1'b0, 18'h00108}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b last=%b addr=%h, want 1 0 00108",
                 n, addr_valid, addr_last, addr);
      end
    end
    addr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({addr_last, addr} !== {1'b0, 18'h00110}) begin
      n_errors++;
      $display("FAIL bp_resume: last=%b addr=%h, want 0 00110", addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if ({addr_last, addr} !== {1'b1, 18'h00118}) begin
      n_errors++;
      $display("FAIL bp_last: last=%b addr=%h, want 1 00118", addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_done: done=%b, want 1", done);
    end
  endtask

  task automatic test_wrap_degenerate();
    logic [AW-1:0] exp_a [3] = '{18'h3FFF8, 18'h00000, 18'h00008};
    addr_ready = 1'b1;
    launch(4'd1, 18'h3FFF8, 17'd3, 17'd1, 18'd8, 18'd0);
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if ({addr_last, addr} !== {(n == 2), exp_a[n]}) begin
        n_errors++;
        $display("FAIL wrap_addr[%0d]: last=%b addr=%h, want %b %h",
                 n, addr_last, addr, (n == 2), exp_a[n]);
      end
      @(negedge clk);
    end
    @(negedge clk);
    launch(4'd0, 18'h00ABC, 17'd0, 17'd3, 18'd4, 18'd4);
    n_checks++;
    if ({addr_valid, addr_last, addr} !== {1'b1, 1'b1, 18'h00ABC}) begin
      n_errors++;
      $display("FAIL degen_addr: valid=%b last=%b addr=%h, want 1 1 00abc",
               addr_valid, addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if ({done, addr_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL degen_done: done=%b valid=%b, want 1 0", done, addr_valid);
    end
  endtask

  task automatic test_start_while_busy();
    logic [AW-1:0] exp_a [4] = '{18'h00100, 18'h00108, 18'h00110, 18'h00118};
    addr_ready = 1'b1;
    launch(4'd1, 18'h00100, 17'd4, 17'd1, 18'd8, 18'd0);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if ({addr_last, addr} !== {(n == 3), exp_a[n]}) begin
        n_errors++;
        $display("FAIL busy_start_addr[%0d]: last=%b addr=%h, want %b %h",
                 n, addr_last, addr, (n == 3), exp_a[n]);
      end
      if (n == 1) begin
        set_cfg(4'd2, 18'h02000, 17'd2, 17'd2, 18'd1, 18'd1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL busy_start_done: done=%b busy=%b, want 1 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    addr_ready = 1'b1;
    launch(4'd1, 18'h00100, 17'd4, 17'd1, 18'd8, 18'd0);
    @(negedge clk);
    n_checks++;
    if (addr !== 18'h00108) begin
      n_errors++;
      $display("FAIL rst_mid_pre: addr=%h, want 00108", addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({addr_valid, addr, addr_last, busy, done} !== {1'b0, 18'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL rst_mid_state: valid=%b addr=%h last=%b busy=%b done=%b, want all 0",
               addr_valid, addr, addr_last, busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_nodone: done=%b, want 0", done);
    end
    launch(4'd1, 18'h00500, 17'd2, 17'd1, 18'd4, 18'd0);
    n_checks++;
    if ({addr_valid, addr_last, addr} !== {1'b1, 1'b0, 18'h00500}) begin
      n_errors++;
      $display("FAIL rst_mid_restart0: valid=%b last=%b addr=%h, want 1 0 00500",
               addr_valid, addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if ({addr_last, addr} !== {1'b1, 18'h00504}) begin
      n_errors++;
      $display("FAIL rst_mid_restart1: last=%b addr=%h, want 1 00504", addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_done: done=%b, want 1", done);
    end
  endtask

  task automatic test_back_to_back();
    addr_ready = 1'b1;
    launch(4'd1, 18'h00200, 17'd2, 17'd1, 18'd4, 18'd0);
    @(negedge clk);
    n_checks++;
    if ({addr_last, addr} !== {1'b1, 18'h00204}) begin
      n_errors++;
      $display("FAIL b2b_last: last=%b addr=%h, want 1 00204", addr_last, addr);
    end
    @(negedge clk);
    n_checks++;
    if ({done, addr_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL b2b_gap: done=%b valid=%b, want 1 0", done, addr_valid);
    end
    set_cfg(4'd1, 18'h00300, 17'd1, 17'd1, 18'd4, 18'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({addr_valid, addr_last, addr, done} !== {1'b1, 1'b1, 18'h00300, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_second: valid=%b last=%b addr=%h done=%b, want 1 1 00300 0",
               addr_valid, addr_last, addr, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_done: done=%b, want 1", done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    addr_ready = 1'b1;
    start      = 1'b0;
    reset      = 1'b1;
    test_reset();
    test_1d();
    test_2d_carry();
    test_backpressure();
    test_wrap_degenerate();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glb_ld_addr_gen.md
# glb_ld_addr_gen

Load-DMA address generator for a GLB tile. It walks a programmable nested loop of up to LOOP_LEVEL dimensions and emits one bank byte-address per handshake. Its output stream feeds the tile's load-DMA bank-read request path, ahead of the GLB_DMA2BANK_DELAY pipeline. Configuration is captured at start, so the register file may be rewritten while a transfer is in flight.

## Interface
Parameters:
- LOOP_LEVEL, 8, maximum number of loop dimensions
- GLB_ADDR_WIDTH, 18, width of the address, start and stride fields
- RANGE_WIDTH, 17, width of each per-dimension iteration count
- DIM_WIDTH, 4, width of cfg_dim

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- cfg_dim  in  DIM_WIDTH  number of active dimensions
- cfg_start_addr  in  GLB_ADDR_WIDTH  base byte address
- cfg_range  in  LOOP_LEVEL*RANGE_WIDTH  packed per-dimension iteration counts; dimension 0 occupies the LSBs
- cfg_stride  in  LOOP_LEVEL*GLB_ADDR_WIDTH  packed per-dimension byte strides, unsigned
- start  in  1  single-cycle launch pulse
- addr_valid  out  1  addr is valid
- addr_ready  in  1  consumer accepts addr
- addr  out  GLB_ADDR_WIDTH  generated byte address
- addr_last  out  1  addr is the final address of the transfer
- busy  out  1  transfer in progress
- done  out  1  single-cycle pulse after the final address is accepted

## Operation
- States: IDLE, RUN.
- IDLE, start=1:
  - latch all cfg_* inputs
  - clear every iterator i[k]
  - set addr=cfg_start_addr, addr_valid=1, busy=1
  - compute addr_last
  - go to RUN
- Effective dimension count D = clamp(cfg_dim, 1, LOOP_LEVEL). Dimensions k ≥ D are ignored.
- A cfg_range value of 0 is treated as 1.
- Address formula: addr = start + Σ_{k<D} i[k]*stride[k], modulo 2^GLB_ADDR_WIDTH. Wrap-around is silent; no error is flagged.
- Implementation: incremental. Keep one registered partial base per level; no multipliers.
- Fire means addr_valid && addr_ready. On a fire that is not last:
  - i[0] increments
  - when i[k] == range[k]-1 and it is carried into, i[k] clears to 0 and the carry propagates to i[k+1]
  - addr updates to the new formula value
- addr_last = 1 exactly when i[k] == range[k]-1 for every k < D.
- On the fire of the last address:
  - addr_valid → 0, busy → 0
  - done = 1 for one cycle
  - go to IDLE
- start while busy=1 is ignored. cfg_* inputs are don't-care in RUN.
- addr_valid never drops without a fire, except on reset.
- addr and addr_last are stable while addr_valid && !addr_ready.

## Timing
- Reset (synchronous, at clk edge):
  - state=IDLE, iterators=0
  - addr_valid=0, addr=0, addr_last=0, busy=0, done=0
- A reset asserted mid-transfer aborts the transfer. No done pulse is produced.
- All outputs are registered.
- Start pulse at edge t: addr_valid, first addr and busy are visible after edge t (cycle t+1).
- Throughput: one address per cycle while addr_ready=1. There are no bubbles, including across carries at any level.
- done is asserted in the cycle after the edge that fires the last address. busy falls on that same edge.
- Back-to-back transfers: start may be asserted in the same cycle as done. The first address of the new transfer then appears one cycle later, leaving one idle cycle minimum between transfers.
- start and reset asserted together: reset wins.

## Test plan
- 1-D streaming:
  - stimulus: dim=1, start=0x00100, range0=4, stride0=8, addr_ready held 1
  - response: addr 0x00100, 0x00108, 0x00110, 0x00118 on consecutive cycles; addr_last only on 0x00118; done one cycle later; busy low thereafter
- 2-D carry:
  - stimulus: dim=2, start=0, range={3,2}, stride={2,0x40}
  - response: 0x0, 0x2, 0x4, 0x40, 0x42, 0x44 with no gaps; addr_last on 0x44
- Backpressure:
  - stimulus: the 1-D case with addr_ready=0 for 3 cycles while addr=0x00108
  - response: addr, addr_valid and addr_last held; sequence resumes 0x00110 with no address skipped or duplicated
- Wrap and degenerate configuration:
  - case 1: start=0x3FFF8, stride0=8, range0=3 → 0x3FFF8, 0x00000, 0x00008
  - case 2: dim=0, range0=0 → single address equal to start, with addr_last=1
- Start while busy:
  - stimulus: start re-pulsed mid-transfer with different cfg_* values
  - response: the original sequence completes unchanged
- Reset mid-run:
  - stimulus: reset at the 3rd address
  - response: next cycle all outputs 0, no done pulse; a new start then runs cleanly from its start address
